// File: rtl/fu_scoreboard_pkg.sv
// scb_pkg: unit indices and per-unit scoreboard entry shared by the scoreboard files.
package scb_pkg;
    localparam int FU_ALU = 0;
    localparam int FU_MEM = 1;
    localparam int FU_MUL = 2;
    localparam int FU_DIV = 3;
    localparam int FU_JUMP = 4;
    localparam int SCB_REG_AW = 5;
    typedef struct packed {
        logic                  busy;
        logic [SCB_REG_AW-1:0] rd;
        logic                  rd_we;
    } scb_entry_t;
endpackage

// File: rtl/fu_scoreboard_wb_arbiter.sv
// scb_wb_arbiter: one-of-NUM_FU writeback grant; round-robin when SCB_RR_ARB_EN
// is defined, otherwise fixed priority with the lowest index winning.
module scb_wb_arbiter #(
    parameter int NUM_FU = 5,
    parameter int FU_W   = $clog2(NUM_FU)
) (
`ifdef SCB_RR_ARB_EN
    input  logic              clk,
    input  logic              rst,
`endif
    input  logic [NUM_FU-1:0] req,
    output logic [NUM_FU-1:0] gnt,
    output logic [FU_W-1:0]   idx
);
    logic [FU_W-1:0] j;
`ifdef SCB_RR_ARB_EN
    logic [FU_W-1:0] ptr_q, ptr_d;
    // Descending scan so the entry closest after the pointer is written last.
    always_comb begin
        idx = '0;
        j = '0;
        for (int k = NUM_FU; k >= 1; k--) begin
            j = FU_W'((int'(ptr_q) + k) % NUM_FU);
            if (req[j]) idx = j;
        end
        ptr_d = |req ? idx : ptr_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end
`else
    always_comb begin
        idx = '0;
        j = '0;
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            j = FU_W'(i);
            if (req[j]) idx = j;
        end
    end
`endif
    assign gnt = |req ? NUM_FU'(1) << idx : '0;
endmodule

// File: rtl/fu_scoreboard.sv
// fu_scoreboard: issue/writeback scoreboard for NUM_FU concurrently busy units.
// Define SCB_RR_ARB_EN for round-robin writeback arbitration.
module fu_scoreboard
    import scb_pkg::*;
#(
    parameter int NUM_FU  = 5,
    parameter int FU_W    = $clog2(NUM_FU),
    parameter int REG_NUM = 32,
    parameter int REG_AW  = SCB_REG_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_valid,
    input  logic [FU_W-1:0]    issue_fu,
    input  logic [REG_AW-1:0]  issue_rd,
    input  logic               issue_rd_we,
    input  logic [REG_AW-1:0]  issue_rs1,
    input  logic               issue_rs1_use,
    input  logic [REG_AW-1:0]  issue_rs2,
    input  logic               issue_rs2_use,
    output logic               issue_ready,
    output logic [NUM_FU-1:0]  fu_en,
    input  logic [NUM_FU-1:0]  fu_done,
    output logic [NUM_FU-1:0]  fu_ack,
    output logic               wb_we,
    output logic [REG_AW-1:0]  wb_rd,
    output logic [FU_W-1:0]    wb_sel,
    output logic [NUM_FU-1:0]  fu_busy,
    output logic [REG_NUM-1:0] reg_pending
);
    scb_entry_t         ent_q [NUM_FU];
    scb_entry_t         ent_d [NUM_FU];
    logic [REG_NUM-1:0] pend_q, pend_d;
    logic [NUM_FU-1:0]  busy, req, gnt;
    logic [FU_W-1:0]    gidx;
    logic               legal, fire, any, new_we;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_busy
        assign busy[i] = ent_q[i].busy;
    end

    assign legal = {1'b0, issue_fu} < (FU_W+1)'(NUM_FU);
    assign issue_ready = legal && !busy[issue_fu]
                      && !(issue_rs1_use && pend_q[issue_rs1])
                      && !(issue_rs2_use && pend_q[issue_rs2])
                      && !(issue_rd_we && pend_q[issue_rd]);
    assign fire   = issue_valid && issue_ready && rst;
    assign new_we = issue_rd_we && issue_rd != '0;
    assign fu_en  = fire ? NUM_FU'(1) << issue_fu : '0;
    assign req    = fu_done & busy;
    assign any    = |req;

    scb_wb_arbiter #(.NUM_FU(NUM_FU), .FU_W(FU_W)) u_arb (
`ifdef SCB_RR_ARB_EN
        .clk(clk),
        .rst(rst),
`endif
        .req(req),
        .gnt(gnt),
        .idx(gidx)
    );

    assign fu_ack      = gnt;
    assign wb_sel      = gidx;
    assign wb_rd       = any ? ent_q[gidx].rd : '0;
    assign wb_we       = any && ent_q[gidx].rd_we;
    assign fu_busy     = busy;
    assign reg_pending = pend_q;

    // Grant and fire never hit the same unit: a granted unit is busy and so cannot issue.
    always_comb begin
        ent_d = ent_q;
        pend_d = pend_q;
        if (any) begin
            ent_d[gidx].busy = 1'b0;
            if (ent_q[gidx].rd_we) pend_d[ent_q[gidx].rd] = 1'b0;
        end
        if (fire) begin
            ent_d[issue_fu] = '{busy: 1'b1, rd: issue_rd, rd_we: new_we};
            if (new_we) pend_d[issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_FU; i++) ent_q[i] <= '0;
            pend_q <= '0;
        end else begin
            ent_q <= ent_d;
            pend_q <= pend_d;
        end
    end
endmodule

// File: tb/tb_fu_scoreboard.sv
// tb_fu_scoreboard: directed plan plus randomized issue/done traffic, checked by a
// negedge monitor against a register-set model and a queue of expected writebacks.
module tb_fu_scoreboard;
    logic        clk = 1'b0, rst = 1'b0;
    logic        issue_valid = 1'b0, issue_rd_we = 1'b0, issue_rs1_use = 1'b0, issue_rs2_use = 1'b0;
    logic [2:0]  issue_fu = '0;
    logic [4:0]  issue_rd = '0, issue_rs1 = '0, issue_rs2 = '0;
    logic [4:0]  fu_en, fu_ack, fu_busy, wb_rd;
    logic [4:0]  fu_done = '0;
    logic        wb_we, issue_ready;
    logic [2:0]  wb_sel;
    logic [31:0] reg_pending;

    int errors = 0, checks = 0;

    typedef struct {int fu; bit [4:0] rd; bit we;} exp_t;
    exp_t    exp_q[$];
    int      ack_log[$];
    bit [4:0]  m_busy, ack_seen, start_seen, done_req, done_clr;
    bit [31:0] m_pend;
    int        m_ptr;
    bit        auto_mode = 1'b0;
    int        lat[5];
    bit        lp[5];

    fu_scoreboard dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_fu(issue_fu),
        .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
        .issue_rs1(issue_rs1), .issue_rs1_use(issue_rs1_use),
        .issue_rs2(issue_rs2), .issue_rs2_use(issue_rs2_use),
        .issue_ready(issue_ready), .fu_en(fu_en), .fu_done(fu_done), .fu_ack(fu_ack),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_sel(wb_sel),
        .fu_busy(fu_busy), .reg_pending(reg_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input int fu, input int rd, input bit we, input int r1, input bit u1,
                         input int r2, input bit u2);
        issue_valid = 1'b1;
        issue_fu = 3'(fu);
        issue_rd = 5'(rd);
        issue_rd_we = we;
        issue_rs1 = 5'(r1);
        issue_rs1_use = u1;
        issue_rs2 = 5'(r2);
        issue_rs2_use = u2;
    endtask

    // Reference model and scoreboard: predicts ready/fu_en/grant and pops expected writebacks.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = '0;
            m_pend = '0;
            m_ptr = 0;
            exp_q.delete();
            ack_seen = '0;
            start_seen = '0;
        end else begin
            bit exp_rdy, fire;
            bit [4:0] cand;
            int g, a;
            int hits[$];
            chk("fu_busy", 32'(fu_busy), 32'(m_busy));
            chk("reg_pending", reg_pending, m_pend);
            exp_rdy = issue_fu < 5 && !m_busy[issue_fu]
                   && !(issue_rs1_use && m_pend[issue_rs1])
                   && !(issue_rs2_use && m_pend[issue_rs2])
                   && !(issue_rd_we && m_pend[issue_rd]);
            fire = issue_valid && exp_rdy;
            chk("issue_ready", 32'(issue_ready), 32'(exp_rdy));
            chk("fu_en", 32'(fu_en), fire ? 32'(1) << issue_fu : 32'(0));
            cand = fu_done & m_busy;
            g = -1;
`ifdef SCB_RR_ARB_EN
            for (int k = 5; k >= 1; k--) if (cand[(m_ptr + k) % 5]) g = (m_ptr + k) % 5;
`else
            for (int i = 4; i >= 0; i--) if (cand[i]) g = i;
`endif
            chk("fu_ack", 32'(fu_ack), g >= 0 ? 32'(1) << g : 32'(0));
            a = -1;
            for (int i = 4; i >= 0; i--) if (fu_ack[i]) a = i;
            if (a >= 0) ack_log.push_back(a);
            if (g >= 0) begin
                hits = exp_q.find_index with (item.fu == g);
                chk("wb_entry_found", hits.size(), 1);
                if (hits.size() > 0) begin
                    chk("wb_sel", 32'(wb_sel), g);
                    chk("wb_rd", 32'(wb_rd), 32'(exp_q[hits[0]].rd));
                    chk("wb_we", 32'(wb_we), 32'(exp_q[hits[0]].we));
                    if (exp_q[hits[0]].we) m_pend[exp_q[hits[0]].rd] = 1'b0;
                    exp_q.delete(hits[0]);
                end
                m_busy[g] = 1'b0;
                m_ptr = g;
            end else begin
                chk("idle_wb_we", 32'(wb_we), 0);
                chk("idle_wb_rd", 32'(wb_rd), 0);
                chk("idle_wb_sel", 32'(wb_sel), 0);
            end
            if (fire) begin
                exp_q.push_back('{fu: int'(issue_fu), rd: issue_rd, we: issue_rd_we && issue_rd != 0});
                m_busy[issue_fu] = 1'b1;
                if (issue_rd_we && issue_rd != 0) m_pend[issue_rd] = 1'b1;
            end
            ack_seen = fu_ack;
            start_seen = fu_en;
        end
    end

    // Functional-unit stand-ins: hold done until acked; random latency in auto mode.
    initial forever begin
        cyc();
        if (!rst) begin
            fu_done = '0;
            for (int u = 0; u < 5; u++) lp[u] = 1'b0;
        end else begin
            fu_done = (fu_done & ~ack_seen & ~done_clr) | done_req;
            done_req = '0;
            done_clr = '0;
            for (int u = 0; u < 5; u++) begin
                if (auto_mode && start_seen[u]) begin
                    lat[u] = $urandom_range(0, 4);
                    lp[u] = 1'b1;
                end else if (lp[u]) begin
                    if (lat[u] == 0) begin
                        fu_done[u] = 1'b1;
                        lp[u] = 1'b0;
                    end else lat[u]--;
                end
            end
        end
    end

    initial begin
        int t;
        #3;
        chk("rst_busy", 32'(fu_busy), 0);
        chk("rst_pending", reg_pending, 0);
        chk("rst_ack", 32'(fu_ack), 0);
        chk("rst_wb_we", 32'(wb_we), 0);
        chk("rst_fu_en", 32'(fu_en), 0);
        chk("rst_ready", 32'(issue_ready), 1);
        cyc(); rst = 1'b1;
        cyc(); issue(2, 5, 1, 0, 0, 0, 0);
        mid(); chk("t1_ready", 32'(issue_ready), 1); chk("t1_fu_en", 32'(fu_en), 32'b00100);
        cyc(); issue_valid = 1'b0;
        mid(); chk("t1_busy", 32'(fu_busy), 32'b00100); chk("t1_pend5", 32'(reg_pending[5]), 1);
        cyc(); issue(0, 1, 1, 5, 1, 0, 0);
        mid(); chk("raw_stall", 32'(issue_ready), 0); done_req = 5'b00100;
        cyc();
        mid();
        chk("raw_ack", 32'(fu_ack), 32'b00100); chk("raw_wb_rd", 32'(wb_rd), 5);
        chk("raw_wb_we", 32'(wb_we), 1); chk("raw_wb_sel", 32'(wb_sel), 2);
        chk("raw_stall_ack", 32'(issue_ready), 0);
        cyc();
        mid(); chk("raw_release", 32'(issue_ready), 1);
        cyc(); issue(3, 0, 1, 0, 0, 0, 0);
        mid(); chk("x0_ready", 32'(issue_ready), 1);
        cyc(); issue(3, 6, 1, 0, 0, 0, 0);
        mid(); chk("struct_stall", 32'(issue_ready), 0); chk("x0_pending", reg_pending, 32'h2);
        done_req = 5'b01000;
        cyc(); issue_valid = 1'b0;
        mid(); chk("x0_ack", 32'(fu_ack), 32'b01000); chk("x0_wb_we", 32'(wb_we), 0);
        done_req = 5'b00001;
        cyc();
        mid(); chk("u0_ack", 32'(fu_ack), 32'b00001); chk("u0_wb_rd", 32'(wb_rd), 1);
        cyc(); issue(scb_pkg::FU_MEM, 0, 0, 0, 0, 0, 0);
        mid(); done_req = 5'b00010;
        cyc(); issue_valid = 1'b0;
        mid(); chk("nodest_ack", 32'(fu_ack), 32'b00010); chk("nodest_wb_we", 32'(wb_we), 0);
        cyc(); issue(1, 7, 1, 0, 0, 0, 0);
        mid();
        cyc(); issue(2, 8, 1, 0, 0, 0, 0);
        mid();
        cyc(); issue(4, 9, 1, 0, 0, 0, 0);
        mid(); ack_log.delete(); done_req = 5'b10110;
        cyc(); issue_valid = 1'b0;
        mid(); cyc(); mid(); cyc(); mid();
        chk("arb_count", ack_log.size(), 3);
        if (ack_log.size() == 3) begin
`ifdef SCB_RR_ARB_EN
            chk("arb_first", ack_log[0], 2); chk("arb_second", ack_log[1], 4); chk("arb_third", ack_log[2], 1);
`else
            chk("arb_first", ack_log[0], 1); chk("arb_second", ack_log[1], 2); chk("arb_third", ack_log[2], 4);
`endif
        end
        cyc();
        mid(); chk("arb_pending_clear", reg_pending, 0); chk("arb_busy_clear", 32'(fu_busy), 0);
        done_req = 5'b00001;
        cyc();
        mid(); chk("spurious_ack", 32'(fu_ack), 0); chk("spurious_wb_we", 32'(wb_we), 0);
        done_clr = 5'b00001;
        cyc(); issue(1, 10, 1, 0, 0, 0, 0);
        cyc(); issue(2, 11, 1, 0, 0, 0, 0);
        cyc(); issue(3, 12, 1, 0, 0, 0, 0);
        cyc(); issue_valid = 1'b0;
        mid(); chk("pre_rst_busy", 32'(fu_busy), 32'b01110); chk("pre_rst_pend", reg_pending, 32'h1c00);
        cyc(); #1; rst = 1'b0; #1;
        chk("arst_busy", 32'(fu_busy), 0);
        chk("arst_pending", reg_pending, 0);
        chk("arst_ack", 32'(fu_ack), 0);
        chk("arst_wb_we", 32'(wb_we), 0);
        chk("arst_fu_en", 32'(fu_en), 0);
        cyc(); #1; rst = 1'b1;
        auto_mode = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            issue($urandom % 7, $urandom % 8, 1'($urandom), $urandom % 8, 1'($urandom),
                  $urandom % 8, 1'($urandom));
            issue_valid = ($urandom % 4) != 0;
        end
        cyc(); issue_valid = 1'b0;
        t = 0;
        while (m_busy != 0 && t < 200) begin
            cyc();
            t++;
        end
        chk("drain_busy", 32'(m_busy), 0);
        mid(); chk("drain_queue", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/fu_scoreboard.md
# fu_scoreboard

Parametrised issue/writeback scoreboard for the multi-cycle functional-unit core. It sits between the ID-stage decoder and a bank of NUM_FU functional units. It blocks issue on structural, RAW and WAW hazards. It tracks per-register pending writes and arbitrates the single register-file write port among completing units. It succeeds the fixed five-unit, one-instruction-in-flight control by allowing every unit to be busy concurrently.

## Interface
Parameters:
- NUM_FU, 5, number of functional units (2..8)
- FU_W, $clog2(NUM_FU), unit index width
- REG_NUM, 32, architectural registers; register 0 is hard-wired zero
- REG_AW, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- issue_valid  in  1  decoder presents an instruction
- issue_fu  in  FU_W  target unit index
- issue_rd / issue_rd_we  in  REG_AW / 1  destination register and write flag
- issue_rs1 / issue_rs1_use  in  REG_AW / 1  source 1 and use flag
- issue_rs2 / issue_rs2_use  in  REG_AW / 1  source 2 and use flag
- issue_ready  out  1  combinational; issue fires when issue_valid && issue_ready
- fu_en  out  NUM_FU  one-hot start pulse, same cycle as fire
- fu_done  in  NUM_FU  unit result valid; level, held until acked
- fu_ack  out  NUM_FU  one-hot writeback grant, combinational
- wb_we  out  1  register-file write enable
- wb_rd  out  REG_AW  write address
- wb_sel  out  FU_W  result-mux select, the granted unit index
- fu_busy  out  NUM_FU  registered unit-occupied vector
- reg_pending  out  REG_NUM  registered pending-write vector; bit 0 always 0

## Operation
- Per-unit entry: busy, rd, rd_we.
- Per-register pending bit.
- issue_ready = !busy[issue_fu] && !(rs1_use && pending[rs1]) && !(rs2_use && pending[rs2]) && !(rd_we && pending[rd]) && issue_fu < NUM_FU.
- All hazard terms use registered state.
- On fire:
  - set busy[issue_fu] and latch rd and rd_we.
  - If rd_we && rd != 0, set pending[rd].
  - Pulse fu_en[issue_fu].
  - If rd_we && rd == 0, latch rd_we as 0.
- Writeback candidates: fu_done & busy. fu_done on a non-busy unit is ignored and never acked.
- Arbiter grants one candidate per cycle. The grant drives:
  - fu_ack[g] = 1
  - wb_sel = g
  - wb_rd = rd[g]
  - wb_we = rd_we[g]
- Units without a destination (stores, branches) are still acked, with wb_we = 0.
- At the grant edge: clear busy[g] and pending[rd[g]]. The unit drops fu_done the cycle after fu_ack.
- With no candidate, fu_ack = 0, wb_we = 0, wb_rd = 0 and wb_sel = 0.

## Timing
- Reset (rst low, asynchronous):
  - busy, pending and the arbiter pointer clear to 0.
  - fu_en, fu_ack and wb_we read 0.
  - issue_ready reads 1 once issue_valid targets a legal unit.
- Reset mid-operation discards all in-flight entries. Units must be reset by the same rst.
- Issue-to-fu_en latency is 0 cycles. fu_en is high exactly one cycle per fire.
- Minimum fu_done-to-fu_ack latency is 0 cycles. A unit waits one cycle per competing higher-priority grant.
- Issue and writeback may fire in the same cycle on different units.
- A dependent instruction whose source or destination is being written back this cycle stalls exactly one cycle, because pending clears at the edge.
- Issue to a unit being acked this cycle stalls one cycle, because busy clears at the edge.
- Simultaneous set and clear of the same pending bit is impossible, because WAW blocks it.
- Back-to-back issue to distinct free units is possible on every cycle.

## Configuration
- SCB_RR_ARB_EN defined: round-robin writeback arbitration.
  - The pointer holds the last granted index.
  - The search starts at pointer+1 and wraps at NUM_FU−1 → 0.
  - The pointer updates only on a grant.
- SCB_RR_ARB_EN undefined: fixed priority, lowest index wins. No pointer register.

## Structure
- Package scb_pkg holds:
  - unit index localparams: FU_ALU=0, FU_MEM=1, FU_MUL=2, FU_DIV=3, FU_JUMP=4
  - the entry struct {busy, rd, rd_we}
- One sub-module, scb_wb_arbiter (parametrised NUM_FU; request vector in, one-hot grant and index out), containing both arbitration variants under the macro.

## Test plan
- Reset, then issue rd=x5 to unit 2 → fu_en=5'b00100, fu_busy=5'b00100, reg_pending[5]=1 on the next cycle.
- With x5 pending, issue rs1=x5 to unit 0 → issue_ready=0 until the cycle after unit 2 is acked with wb_rd=5 and wb_we=1.
- Issue to unit 3 while unit 3 is busy → issue_ready=0. Issue rd=x0 with rd_we=1 → reg_pending stays 0, and at ack wb_we=0.
- Units 1, 2 and 4 assert fu_done in the same cycle:
  - fixed priority → acks in order 1, 2, 4;
  - SCB_RR_ARB_EN with pointer=1 → acks in order 2, 4, 1.
- Assert fu_done on idle unit 0 → fu_ack=0 and wb_we=0.
- Pull rst low with three units busy → all outputs and the pending vector are 0 immediately, without a clock edge.
